exe_div_ctrl: RTL and testbench

- Iterative divider and sequencer for the EXE stage: radix-2 restoring divide, one quotient bit per cycle, signed and unsigned.
- Sits beside the single-cycle ALU. Stalls EXE through exe_ready_go while a divide is in flight.
- Holds the result until MEM accepts it, and discards in-flight work on flush.

---
 rtl/exe_div_ctrl_if.sv | 33 +++
 rtl/exe_div_ctrl.sv | 119 +++++++++++
 tb/tb_exe_div_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_div_ctrl_if.sv
// EXE-stage divider handshake bundle.
// master = EXE/MEM side, slave = divider.
interface exe_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_valid;
  logic             div_signed;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             flush;
  logic             out_ready;
  logic             exe_ready_go;
  logic             busy;
  logic             res_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_valid, div_signed,
    output div_src1, div_src2,
    output flush, out_ready,
    input  exe_ready_go, busy, res_valid,
    input  quotient, remainder
  );

  modport slave (
    input  div_valid, div_signed,
    input  div_src1, div_src2,
    input  flush, out_ready,
    output exe_ready_go, busy, res_valid,
    output quotient, remainder
  );
endinterface

// File: rtl/exe_div_ctrl.sv
// Iterative radix-2 restoring divider for EXE.
// One quotient bit per cycle, signed/unsigned.
module exe_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  exe_div_ctrl_if.slave  dif
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;

  logic             s1n;
  logic             s2n;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             accept;
  logic             by_zero;
  logic             last;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic             bit_ok;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] r_nx;

  assign s1n = dif.div_signed & dif.div_src1[WIDTH-1];
  assign s2n = dif.div_signed & dif.div_src2[WIDTH-1];
  assign a_abs = s1n ? -dif.div_src1 : dif.div_src1;
  assign b_abs = s2n ? -dif.div_src2 : dif.div_src2;
  assign by_zero = (dif.div_src2 == '0);

  assign accept = (state == IDLE) & dif.div_valid
                & ~dif.flush;
  assign last = (cnt == CW'(WIDTH - 1));

  // dvd shifts out dividend bits and shifts in
  // quotient bits, so it ends up as the quotient.
  assign shl = {prem, dvd[WIDTH-1]};
  assign diff = shl - {1'b0, dvs};
  assign bit_ok = ~diff[WIDTH];
  assign q_nx = {dvd[WIDTH-2:0], bit_ok};
  assign r_nx = bit_ok ? diff[WIDTH-1:0]
                       : shl[WIDTH-1:0];

  assign dif.busy = (state == CALC);
  assign dif.res_valid = (state == DONE);
  assign dif.exe_ready_go = (state == DONE)
    | ((state == IDLE) & ~dif.div_valid);
  assign dif.quotient = quot;
  assign dif.remainder = rem;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state; flush overrides everything.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = by_zero ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (dif.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (dif.flush) state_nx = IDLE;
  end

  // Operand latch, iteration and sign fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      prem  <= '0;
      quot  <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      dvd   <= a_abs;
      dvs   <= b_abs;
      prem  <= '0;
      q_neg <= s1n ^ s2n;
      r_neg <= s1n;
      if (by_zero) begin
        quot <= '1;
        rem  <= dif.div_src1;
      end
    end else if ((state == CALC) & ~dif.flush) begin
      cnt  <= cnt + 1'b1;
      dvd  <= q_nx;
      prem <= r_nx;
      if (last) begin
        quot <= q_neg ? -q_nx : q_nx;
        rem  <= r_neg ? -r_nx : r_nx;
      end
    end
  end
endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl.
// Directed cases plus random ops vs arithmetic model.
module tb_exe_div_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  exe_div_ctrl_if #(.WIDTH(W)) dif ();

  exe_div_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] eq;
  logic [W-1:0] er;
  int elat;

  logic [W-1:0] da [7] = '{32'd100, 32'hFFFFFFF9,
    32'd7, 32'h1234, 32'h1234, 32'h80000000,
    32'hFFFFFFFF};
  logic [W-1:0] db [7] = '{32'd7, 32'd2,
    32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF,
    32'd1};
  logic ds [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
    1'b1, 1'b0};
  logic [W-1:0] dq [7] = '{32'd14, 32'hFFFFFFFD,
    32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
    32'h80000000, 32'hFFFFFFFF};
  logic [W-1:0] dr [7] = '{32'd2, 32'hFFFFFFFF,
    32'd1, 32'h1234, 32'h1234, 32'd0, 32'd0};

  function automatic void model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] q,
    output logic [W-1:0] r
  );
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s);
    dif.div_valid  = 1'b1;
    dif.div_signed = s;
    dif.div_src1   = a;
    dif.div_src2   = b;
    model(a, b, s, eq, er);
    elat = (b == '0) ? 0 : W;
  endtask

  task automatic start_op(input string tag,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s);
    drive_op(a, b, s);
    #1;
    chk({tag, ":rdy_idle"}, dif.exe_ready_go, 0);
    tick();
    dif.div_src1   = $urandom;
    dif.div_src2   = $urandom;
    dif.div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int n;
    int stall_bad;
    n = 0;
    stall_bad = 0;
    while (dif.busy === 1'b1 && n < 100) begin
      if (dif.exe_ready_go !== 1'b0 ||
          dif.res_valid !== 1'b0)
        stall_bad++;
      tick();
      n++;
    end
    chk({tag, ":latency"}, n, elat);
    chk({tag, ":stall"}, stall_bad, 0);
    chk({tag, ":res_valid"}, dif.res_valid, 1);
    chk({tag, ":quot"}, dif.quotient, eq);
    chk({tag, ":rem"}, dif.remainder, er);
    chk({tag, ":rdy_done"}, dif.exe_ready_go, 1);
  endtask

  task automatic finish_op(input string tag);
    dif.out_ready = 1'b1;
    dif.div_valid = 1'b0;
    tick();
    chk({tag, ":idle_rv"}, dif.res_valid, 0);
    chk({tag, ":idle_busy"}, dif.busy, 0);
    chk({tag, ":idle_rdy"}, dif.exe_ready_go, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;
    int hold_bad;
    int rv_bad;
    int pick;

    reset          = 1'b1;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_src1   = '0;
    dif.div_src2   = '0;
    dif.flush      = 1'b0;
    dif.out_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst:res_valid", dif.res_valid, 0);
    chk("rst:busy", dif.busy, 0);
    chk("rst:rdy", dif.exe_ready_go, 1);
    chk("rst:quot", dif.quotient, 0);
    chk("rst:rem", dif.remainder, 0);

    for (int i = 0; i < 7; i++) begin
      start_op($sformatf("dir%0d", i),
               da[i], db[i], ds[i]);
      eq = dq[i];
      er = dr[i];
      wait_done($sformatf("dir%0d", i));
      finish_op($sformatf("dir%0d", i));
    end

    dif.out_ready = 1'b0;
    start_op("bp", $urandom,
             W'($urandom_range(1, 5000)), 1'b1);
    wait_done("bp");
    hold_bad = 0;
    repeat (5) begin
      tick();
      if (dif.res_valid !== 1'b1 ||
          dif.quotient !== eq ||
          dif.remainder !== er ||
          dif.exe_ready_go !== 1'b1)
        hold_bad++;
    end
    chk("bp:hold", hold_bad, 0);
    drive_op($urandom,
             W'($urandom_range(1, 300)), 1'b0);
    dif.out_ready = 1'b1;
    tick();
    chk("bp:hs_rv", dif.res_valid, 0);
    chk("bp:hs_busy", dif.busy, 0);
    chk("bp:hs_rdy", dif.exe_ready_go, 0);
    tick();
    chk("bp:accept", dif.busy, 1);
    wait_done("bp2");
    finish_op("bp2");

    start_op("fl", $urandom,
             W'($urandom_range(1, 100)), 1'b1);
    rv_bad = 0;
    repeat (9) begin
      if (dif.res_valid !== 1'b0) rv_bad++;
      tick();
    end
    dif.flush = 1'b1;
    drive_op(32'd9, 32'd3, 1'b0);
    tick();
    dif.flush = 1'b0;
    chk("fl:rv_never", rv_bad, 0);
    chk("fl:rv", dif.res_valid, 0);
    chk("fl:busy", dif.busy, 0);
    chk("fl:rdy", dif.exe_ready_go, 0);
    tick();
    chk("fl:accept", dif.busy, 1);
    eq = 32'd3;
    er = 32'd0;
    wait_done("fl9_3");
    finish_op("fl9_3");

    start_op("rs", $urandom,
             W'($urandom_range(1, 100)), 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    dif.div_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("rs:rv", dif.res_valid, 0);
    chk("rs:busy", dif.busy, 0);
    chk("rs:rdy", dif.exe_ready_go, 1);
    chk("rs:quot", dif.quotient, 0);
    chk("rs:rem", dif.remainder, 0);

    for (int i = 0; i < 20; i++) begin
      pick = $urandom_range(0, 7);
      a = $urandom;
      if (pick == 0)     b = '0;
      else if (pick < 3) b = W'($urandom_range(1, 15));
      else if (pick == 3) b = '1;
      else               b = $urandom;
      s = 1'($urandom_range(0, 1));
      start_op($sformatf("rnd%0d", i), a, b, s);
      wait_done($sformatf("rnd%0d", i));
      finish_op($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
